lcd_read_ctrl: RTL
==================

# lcd_read_ctrl

HD44780-compatible LCD read-cycle controller. It is the read direction of the LCD bus that the existing LCD write driver uses. On request it performs one timed read cycle (`lcd_rw`=1), either of the busy flag and address counter or of a DDRAM/CGRAM data byte, and returns the sampled byte. It also supports a poll mode that repeats busy-flag reads until BF=0 or a timeout, so the write path can replace fixed delays with real busy checks.

## Interface
Parameters:
- `T_AS`, default 2: cycles `lcd_rs`/`lcd_rw` are stable before `lcd_en` rises (≥1).
- `T_EN`, default 12: cycles `lcd_en` is high (≥1).
- `T_H`, default 2: cycles `lcd_rs`/`lcd_rw` are held after `lcd_en` falls (≥1).
- `T_GAP`, default 24: idle cycles between successive reads in poll mode (≥1).
- `MAX_POLLS`, default 255: busy-flag reads before poll timeout (1..65535).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: start request.
- `req_ready` out 1: controller idle; request accepted on `req_valid & req_ready`.
- `req_rs` in 1: 0 = busy-flag/address read, 1 = data read.
- `req_poll` in 1: poll until BF=0; honoured only when `req_rs`=0.
- `bus_gnt` in 1: LCD bus granted by top-level arbiter; the controller never starts a read cycle without it.
- `lcd_rs` out 1: LCD register select.
- `lcd_rw` out 1: LCD read/write; 1 only during this block's cycles.
- `lcd_en` out 1: LCD enable strobe.
- `lcd_data_i` in 8: LCD data bus as read from the pad.
- `bus_busy` out 1: high from accept until the response cycle; top level tri-states the writer's data drive while high.
- `rsp_valid` out 1: one-cycle pulse, response valid.
- `rsp_data` out 8: last sampled byte (for `req_rs`=0: bit7 = BF, bits6:0 = address counter).
- `rsp_timeout` out 1: valid with `rsp_valid`; poll ended with BF still 1.

## Operation
- States: IDLE, WAIT_GNT, SETUP, EN_HI, HOLD, GAP, RESP.
- IDLE: `req_ready`=1. On accept, latch `req_rs` and `req_poll & ~req_rs`, clear poll counter, then go to WAIT_GNT.
- WAIT_GNT: `lcd_rw`=0 and `lcd_en`=0. Go to SETUP on the first cycle with `bus_gnt`=1.
- SETUP: `lcd_rs`=latched rs, `lcd_rw`=1, `lcd_en`=0, for T_AS cycles. Then EN_HI.
- EN_HI: `lcd_en`=1 for T_EN cycles. Capture `lcd_data_i` into `rsp_data` at the clock edge that ends the last EN_HI cycle. Then HOLD.
- HOLD: `lcd_en`=0, rs/rw held, for T_H cycles. Then:
  - not polling, or captured bit7=0: go to RESP.
  - polling and bit7=1: increment poll count. If count = MAX_POLLS, go to RESP with timeout. Otherwise go to GAP.
- GAP: `lcd_rw`=0 and `lcd_en`=0 for T_GAP cycles, then WAIT_GNT.
- RESP: `rsp_valid`=1, `rsp_timeout` set as above, `lcd_rw`=0, `bus_busy`=0. Then IDLE.
- `rsp_data` and `rsp_timeout` hold their values until the next response.
- One shared phase counter, width $clog2 of max(T_AS, T_EN, T_H, T_GAP)+1. Poll counter is 16 bits and saturates.
- `bus_gnt` deasserting after SETUP is entered is ignored; the cycle completes.
- `req_valid` while not ready: ignored, no queueing.

## Timing
- Reset values: `lcd_rs`=0, `lcd_rw`=0, `lcd_en`=0, `req_ready`=1, `bus_busy`=0, `rsp_valid`=0, `rsp_data`=8'h00, `rsp_timeout`=0, state IDLE.
- Accept at edge k with `bus_gnt`=1 already high:
  - WAIT_GNT occupies cycle k+1.
  - SETUP occupies cycles k+2..k+1+T_AS.
  - `lcd_en` is high for cycles k+2+T_AS..k+1+T_AS+T_EN.
  - `rsp_valid` is high in cycle k+2+T_AS+T_EN+T_H, which is k+18 with defaults.
- Each extra poll iteration adds T_GAP+1+T_AS+T_EN+T_H cycles (41 with defaults) while the grant is held.
- `lcd_rs` changes only while `lcd_en`=0. `lcd_rw` never falls while `lcd_en`=1.
- Reset asserted mid-cycle: all outputs drop to reset values immediately (asynchronously), with no completion and no response.

## Structure
- Shared package `lcd_pkg`: state enum, default timing constants, and the BF bit index (7) shared with the LCD write driver.
- No sub-module. Phase counter and poll counter are inline. The top level owns the tri-state pad and the arbiter.

## Test plan
- Data read: `req_rs`=1, `lcd_data_i`=8'h41 during EN_HI, grant held → `rsp_valid` at k+18, `rsp_data`=8'h41, `rsp_timeout`=0, `lcd_rs`=1 throughout.
- Poll success: `req_poll`=1, BF model returns 8'h80 for 3 reads then 8'h05 → 4 EN pulses, `rsp_data`=8'h05, `rsp_timeout`=0.
- Poll timeout: MAX_POLLS=4, BF stuck at 8'h9F → exactly 4 EN pulses, `rsp_timeout`=1, `rsp_data`=8'h9F.
- Grant delay: `bus_gnt` low for 10 cycles after accept → `lcd_rw` stays 0 and `lcd_en` stays 0 until grant; response arrives at k+28.
- Reset mid-EN_HI: `reset`=0 during cycle k+8 → `lcd_en` and `lcd_rw` go low within the same cycle, `req_ready`=1, no `rsp_valid`.
- Back-to-back: `req_valid` held high throughout → second accept occurs in the cycle after RESP, and `req_valid` is never accepted while `bus_busy`=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: read-controller state encoding, default bus timing
// and the busy-flag bit position that the write driver also relies on.
package lcd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_GNT,
      S_SETUP,
      S_EN_HI,
      S_HOLD,
      S_GAP,
      S_RESP
   } lcd_state_e;

   localparam int DEF_T_AS      = 2;
   localparam int DEF_T_EN      = 12;
   localparam int DEF_T_H       = 2;
   localparam int DEF_T_GAP     = 24;
   localparam int DEF_MAX_POLLS = 255;

   localparam int LCD_BF_BIT = 7;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/lcd_read_ctrl.sv
// HD44780 read-cycle controller: one timed read of busy flag/address or data,
// with an optional busy-flag poll loop that ends on BF=0 or after MAX_POLLS reads.
module lcd_read_ctrl
   import lcd_pkg::*;
#(
   parameter int T_AS      = DEF_T_AS,
   parameter int T_EN      = DEF_T_EN,
   parameter int T_H       = DEF_T_H,
   parameter int T_GAP     = DEF_T_GAP,
   parameter int MAX_POLLS = DEF_MAX_POLLS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic       req_poll,
   input  logic       bus_gnt,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   input  logic [7:0] lcd_data_i,
   output logic       bus_busy,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_timeout,
   output lcd_state_e dbg_state
);

   localparam int PH_MAX = max4(T_AS, T_EN, T_H, T_GAP);
   localparam int PH_W   = $clog2(PH_MAX + 1);

   localparam logic [PH_W-1:0] AS_LAST  = PH_W'(T_AS - 1);
   localparam logic [PH_W-1:0] EN_LAST  = PH_W'(T_EN - 1);
   localparam logic [PH_W-1:0] H_LAST   = PH_W'(T_H - 1);
   localparam logic [PH_W-1:0] GAP_LAST = PH_W'(T_GAP - 1);
   localparam logic [15:0]     POLL_LIM = 16'(MAX_POLLS);

   lcd_state_e      state_q, state_d;
   logic [PH_W-1:0] phase_q;
   logic            rs_q, poll_q;
   logic [15:0]     poll_cnt_q, poll_inc;
   logic [7:0]      rsp_data_q;
   logic            timeout_q, timeout_d;
   logic            phase_last, timed, bf_set;

   always_comb begin
      state_d    = state_q;
      phase_last = 1'b0;
      timed      = 1'b0;
      timeout_d  = 1'b0;
      bf_set     = rsp_data_q[LCD_BF_BIT];
      poll_inc   = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
      case (state_q)
         S_IDLE:     if (req_valid) state_d = S_WAIT_GNT;
         S_WAIT_GNT: if (bus_gnt) state_d = S_SETUP;
         S_SETUP: begin
            timed      = 1'b1;
            phase_last = (phase_q == AS_LAST);
            if (phase_last) state_d = S_EN_HI;
         end
         S_EN_HI: begin
            timed      = 1'b1;
            phase_last = (phase_q == EN_LAST);
            if (phase_last) state_d = S_HOLD;
         end
         S_HOLD: begin
            timed      = 1'b1;
            phase_last = (phase_q == H_LAST);
            // The byte captured at the end of EN_HI decides whether to poll again.
            if (phase_last) begin
               if (!poll_q || !bf_set) begin
                  state_d = S_RESP;
               end else if (poll_inc == POLL_LIM) begin
                  state_d   = S_RESP;
                  timeout_d = 1'b1;
               end else begin
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            timed      = 1'b1;
            phase_last = (phase_q == GAP_LAST);
            if (phase_last) state_d = S_WAIT_GNT;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         rs_q       <= 1'b0;
         poll_q     <= 1'b0;
         poll_cnt_q <= '0;
         rsp_data_q <= 8'h00;
         timeout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) phase_q <= '0;
         else if (timed)         phase_q <= phase_q + PH_W'(1);
         if (state_q == S_IDLE && req_valid) begin
            rs_q       <= req_rs;
            poll_q     <= req_poll & ~req_rs;
            poll_cnt_q <= '0;
         end
         if (state_q == S_EN_HI && phase_last) rsp_data_q <= lcd_data_i;
         if (state_q == S_HOLD && phase_last && poll_q && bf_set) poll_cnt_q <= poll_inc;
         if (state_q == S_HOLD && state_d == S_RESP) timeout_q <= timeout_d;
      end
   end

   // Bus pins decode straight from state so an async reset clears them at once.
   assign lcd_rw      = (state_q == S_SETUP) || (state_q == S_EN_HI) || (state_q == S_HOLD);
   assign lcd_rs      = rs_q & lcd_rw;
   assign lcd_en      = (state_q == S_EN_HI);
   assign req_ready   = (state_q == S_IDLE);
   assign bus_busy    = (state_q != S_IDLE) && (state_q != S_RESP);
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_data    = rsp_data_q;
   assign rsp_timeout = timeout_q;
   assign dbg_state   = state_q;

endmodule
